// File: rtl/pipelined_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_multiplier_arbiter
// Description : Shares one external pipelined multiplier between NUM_REQ
//               requesters. Round-robin arbitration issues at most one
//               operation per cycle. A tag pipeline {valid, id} runs in
//               lockstep with the multiplier and steers each result back to
//               the requester that issued it. If the head result's
//               destination is not ready, the whole multiplier is frozen
//               through its clock enable.
// Ports       : clk_i, rst_n_i (async, active-low), flush_i
//               req_valid_i / req_ready_o / req_operand_A_i / req_operand_B_i
//               resp_valid_o / resp_ready_i / resp_result_o
//               mul_clk_en_o, mul_valid_o, mul_operand_A_o, mul_operand_B_o
//               mul_result_i, mul_valid_i   (multiplier side)
//               busy_o      (one or more operations in flight)
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_multiplier_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            flush_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_operand_A_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_operand_B_i,
    output logic [NUM_REQ-1:0]              resp_valid_o,
    input  logic [NUM_REQ-1:0]              resp_ready_i,
    output logic [2*DATA_WIDTH-1:0]         resp_result_o,
    output logic                            mul_clk_en_o,
    output logic                            mul_valid_o,
    output logic [DATA_WIDTH-1:0]           mul_operand_A_o,
    output logic [DATA_WIDTH-1:0]           mul_operand_B_o,
    input  logic [2*DATA_WIDTH-1:0]         mul_result_i,
    input  logic                            mul_valid_i,
    output logic                            busy_o
);

    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(LATENCY + 1);

    // Tag pipeline, stage LATENCY-1 lines up with the multiplier output.
    logic [LATENCY-1:0] r_tag_v;
    logic [c_ID_W-1:0]  r_tag_id [LATENCY];
    // Marks stages whose multiplier contents were orphaned by a flush.
    logic [LATENCY-1:0] r_kill;
    logic [c_ID_W-1:0]  r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_head_v;
    logic [c_ID_W-1:0]  w_head_id;
    logic               w_stall;
    logic               w_retire;
    logic               w_arb_en;
    logic               w_issue;
    logic [c_ID_W-1:0]  w_gnt_id;
    logic [c_ID_W-1:0]  w_idx;
    logic [NUM_REQ-1:0] w_gnt;

    // ------------------------------------------------------------------
    // Head of the tag pipeline and stall
    // ------------------------------------------------------------------
    assign w_head_v  = r_tag_v[LATENCY-1];
    assign w_head_id = r_tag_id[LATENCY-1];
    assign w_stall   = w_head_v & ~resp_ready_i[w_head_id];
    assign w_retire  = w_head_v &  resp_ready_i[w_head_id];

    assign mul_clk_en_o  = ~w_stall;
    assign resp_result_o = mul_result_i;

    always_comb begin
        resp_valid_o = '0;
        if (w_head_v) begin
            resp_valid_o[w_head_id] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from ptr+1 upward with wrap. Reset is
    // folded in so no grant is visible while rst_n_i is held low.
    // ------------------------------------------------------------------
    assign w_arb_en = rst_n_i & ~w_stall & ~flush_i;

    always_comb begin
        w_issue  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        w_gnt    = '0;
        if (w_arb_en) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
                w_idx = c_ID_W'((int'(r_ptr) + i) % NUM_REQ);
                if (!w_issue && req_valid_i[w_idx]) begin
                    w_issue       = 1'b1;
                    w_gnt_id      = w_idx;
                    w_gnt[w_idx]  = 1'b1;
                end
            end
        end
    end

    assign req_ready_o     = w_gnt;
    assign mul_valid_o     = w_issue;
    assign mul_operand_A_o = w_issue ? req_operand_A_i[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mul_operand_B_o = w_issue ? req_operand_B_i[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

    // ------------------------------------------------------------------
    // Tag pipeline: advances only with the multiplier clock enable.
    // Flush clears valids regardless of the enable, which also releases
    // a pending stall on the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else if (flush_i) begin
            r_tag_v <= '0;
        end else if (mul_clk_en_o) begin
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_kill <= '0;
        end else if (flush_i) begin
            r_kill <= '1;
        end else if (mul_clk_en_o) begin
            r_kill[0] <= 1'b0;
            for (int i = 1; i < LATENCY; i++) begin
                r_kill[i] <= r_kill[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer and in-flight counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr <= c_ID_W'(NUM_REQ - 1);
        end else if (w_issue) begin
            r_ptr <= w_gnt_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_issue && !w_retire) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else if (!w_issue && w_retire) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign busy_o = (r_cnt != '0);

    // The multiplier's valid must track the tag head while it advances,
    // except for stages whose work was discarded by a flush.
    a_mul_valid_tracks_tag : assert property (
        @(posedge clk_i) disable iff (!rst_n_i)
        (mul_clk_en_o && !r_kill[LATENCY-1]) |-> (mul_valid_i == w_head_v)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipelined_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_multiplier_arbiter
// Description : Self-checking bench for pipelined_multiplier_arbiter with a
//               behavioural clock-enabled multiplier and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_multiplier_arbiter;

    localparam int DW  = 16;
    localparam int NR  = 4;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     resp_ready = '1;
    logic [NR*DW-1:0]  op_a = '0;
    logic [NR*DW-1:0]  op_b = '0;

    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [2*DW-1:0]   resp_result;
    logic              clk_en;
    logic              mul_vo;
    logic [DW-1:0]     mul_a;
    logic [DW-1:0]     mul_b;
    logic [2*DW-1:0]   mul_res;
    logic              mul_vi;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int              id;
        logic [2*DW-1:0] res;
    } exp_t;
    exp_t sb[$];

    pipelined_multiplier_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .LATENCY    (LAT)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_operand_A_i (op_a),
        .req_operand_B_i (op_b),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_result_o   (resp_result),
        .mul_clk_en_o    (clk_en),
        .mul_valid_o     (mul_vo),
        .mul_operand_A_o (mul_a),
        .mul_operand_B_o (mul_b),
        .mul_result_i    (mul_res),
        .mul_valid_i     (mul_vi),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: LAT stages, frozen by clk_en, shares reset.
    logic [LAT-1:0]  m_v;
    logic [2*DW-1:0] m_r [LAT];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_v <= '0;
            for (int i = 0; i < LAT; i++) m_r[i] <= '0;
        end else if (clk_en) begin
            m_v[0] <= mul_vo;
            m_r[0] <= {16'h0, mul_a} * {16'h0, mul_b};
            for (int i = 1; i < LAT; i++) begin
                m_v[i] <= m_v[i-1];
                m_r[i] <= m_r[i-1];
            end
        end
    end
    assign mul_res = m_r[LAT-1];
    assign mul_vi  = m_v[LAT-1];

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if ((resp_valid & resp_ready) != '0) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got resp_valid %b with nothing expected", resp_valid);
                end else begin
                    exp_t e;
                    logic [NR-1:0] ev;
                    e  = sb.pop_front();
                    ev = '0;
                    ev[e.id] = 1'b1;
                    if (resp_valid !== ev || resp_result !== e.res) begin
                        n_fail++;
                        $display("FAIL sb_result: got valid %b result %h expected valid %b result %h",
                                 resp_valid, resp_result, ev, e.res);
                    end
                end
            end
            if ((req_valid & req_ready) != '0) begin
                for (int r = 0; r < NR; r++) begin
                    if (req_ready[r]) begin
                        exp_t e;
                        e.id  = r;
                        e.res = {16'h0, op_a[r*DW +: DW]} * {16'h0, op_b[r*DW +: DW]};
                        sb.push_back(e);
                    end
                end
            end
            if (flush) sb.delete();
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_a[r*DW +: DW] = a;
        op_b[r*DW +: DW] = b;
    endtask

    task automatic test_reset();
        req_valid = '1;
        #3;
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_tests++; if (resp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0000", resp_valid); end
        n_tests++; if (mul_vo !== 1'b0 || clk_en !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got mul_valid %b clk_en %b busy %b expected 0 1 0", mul_vo, clk_en, busy); end
        @(posedge clk); @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0 || clk_en !== 1'b1 || mul_vo !== 1'b0 || mul_a !== 16'h0) begin
            n_fail++; $display("FAIL post_reset: got busy %b clk_en %b mul_valid %b mul_a %h", busy, clk_en, mul_vo, mul_a); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] eg, er;
        resp_ready = '1;
        for (int n = 0; n < 12; n++) begin
            next_cycle();
            req_valid = (n < 8) ? '1 : '0;
            for (int r = 0; r < NR; r++) set_op(r, DW'(n * 17 + r * 3 + 1), DW'(n + r + 2));
            @(negedge clk);
            eg = (n < 8) ? NR'(1 << (n % 4)) : '0;
            er = (n >= 3 && n < 11) ? NR'(1 << ((n - 3) % 4)) : '0;
            n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL rr_grant n=%0d: got %b expected %b", n, req_ready, eg); end
            n_tests++; if (resp_valid !== er) begin n_fail++; $display("FAIL rr_resp n=%0d: got %b expected %b", n, resp_valid, er); end
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] eg, er;
        logic [2*DW-1:0] eres;
        for (int n = 0; n < 6; n++) begin
            next_cycle();
            req_valid = (n == 0) ? 4'b0010 : (n == 1) ? 4'b0100 : 4'b0000;
            set_op(1, 16'd5, 16'd7);
            set_op(2, 16'hFFFF, 16'hFFFF);
            @(negedge clk);
            eg   = (n == 0) ? 4'b0010 : (n == 1) ? 4'b0100 : 4'b0000;
            er   = (n == 3) ? 4'b0010 : (n == 4) ? 4'b0100 : 4'b0000;
            eres = (n == 3) ? 32'd35 : 32'hFFFE0001;
            n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL b2b_grant n=%0d: got %b expected %b", n, req_ready, eg); end
            n_tests++; if (resp_valid !== er) begin n_fail++; $display("FAIL b2b_resp n=%0d: got %b expected %b", n, resp_valid, er); end
            if (n == 0) begin
                n_tests++; if (mul_vo !== 1'b1 || mul_a !== 16'd5 || mul_b !== 16'd7) begin
                    n_fail++; $display("FAIL b2b_operands: got %b %h %h expected 1 0005 0007", mul_vo, mul_a, mul_b); end
            end
            if (n == 2) begin
                n_tests++; if (mul_vo !== 1'b0 || mul_a !== 16'h0 || mul_b !== 16'h0) begin
                    n_fail++; $display("FAIL b2b_idle_operands: got %b %h %h expected 0 0000 0000", mul_vo, mul_a, mul_b); end
            end
            if (n == 3 || n == 4) begin
                n_tests++; if (resp_result !== eres) begin n_fail++; $display("FAIL b2b_result n=%0d: got %h expected %h", n, resp_result, eres); end
            end
            if (n == 5) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b expected 0", busy); end
            end
        end
    endtask

    task automatic test_stall();
        logic [NR-1:0] eg, er;
        for (int n = 0; n < 12; n++) begin
            next_cycle();
            req_valid  = (n == 0) ? 4'b0001 : (n <= 7) ? 4'b0010 : 4'b0000;
            resp_ready = (n < 7) ? 4'b1110 : 4'b1111;
            set_op(0, 16'd3, 16'd4);
            set_op(1, 16'd6, 16'd7);
            @(negedge clk);
            eg = (n == 0) ? 4'b0001 : (n <= 2 || n == 7) ? 4'b0010 : 4'b0000;
            er = (n >= 3 && n <= 7) ? 4'b0001 : (n >= 8 && n <= 10) ? 4'b0010 : 4'b0000;
            n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL stall_grant n=%0d: got %b expected %b", n, req_ready, eg); end
            n_tests++; if (resp_valid !== er) begin n_fail++; $display("FAIL stall_resp n=%0d: got %b expected %b", n, resp_valid, er); end
            n_tests++; if (clk_en !== !(n >= 3 && n <= 6)) begin n_fail++; $display("FAIL stall_clk_en n=%0d: got %b expected %b", n, clk_en, !(n >= 3 && n <= 6)); end
            if (n >= 3 && n <= 7) begin
                n_tests++; if (resp_result !== 32'd12) begin n_fail++; $display("FAIL stall_result_hold n=%0d: got %h expected 0000000c", n, resp_result); end
            end
            if (n == 11) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy: got %b expected 0", busy); end
            end
        end
    endtask

    task automatic test_single_requester();
        for (int n = 0; n < 14; n++) begin
            next_cycle();
            req_valid = (n < 10) ? 4'b1000 : 4'b0000;
            set_op(3, DW'(n + 2), DW'(n + 100));
            @(negedge clk);
            n_tests++; if (req_ready !== ((n < 10) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL single_grant n=%0d: got %b", n, req_ready); end
            n_tests++; if (resp_valid !== ((n >= 3 && n <= 12) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL single_resp n=%0d: got %b", n, resp_valid); end
            n_tests++; if (busy !== (n >= 1 && n <= 12)) begin n_fail++; $display("FAIL single_busy n=%0d: got %b expected %b", n, busy, (n >= 1 && n <= 12)); end
        end
    endtask

    task automatic test_flush();
        logic [NR-1:0] eg, er;
        for (int n = 0; n < 12; n++) begin
            next_cycle();
            req_valid = (n <= 2) ? NR'(1 << n) : (n == 3 || n == 7) ? 4'b1000 : 4'b0000;
            flush     = (n == 3);
            for (int r = 0; r < NR; r++) set_op(r, DW'(16'h0100 + r), DW'(r + 9));
            set_op(3, (n == 7) ? 16'h1234 : 16'h0055, 16'h0010);
            @(negedge clk);
            eg = (n <= 2) ? NR'(1 << n) : (n == 7) ? 4'b1000 : 4'b0000;
            er = (n == 3) ? 4'b0001 : (n == 10) ? 4'b1000 : 4'b0000;
            n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL flush_grant n=%0d: got %b expected %b", n, req_ready, eg); end
            n_tests++; if (resp_valid !== er) begin n_fail++; $display("FAIL flush_resp n=%0d: got %b expected %b", n, resp_valid, er); end
            if (n == 3) begin
                n_tests++; if (busy !== 1'b1 || mul_vo !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: got busy %b mul_valid %b expected 1 0", busy, mul_vo); end
            end
            if (n == 4 || n == 11) begin
                n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy n=%0d: got %b expected 0", n, busy); end
            end
            if (n == 10) begin
                n_tests++; if (resp_result !== 32'h00012340) begin n_fail++; $display("FAIL flush_new_result: got %h expected 00012340", resp_result); end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 4; n++) begin
            next_cycle();
            req_valid = (n <= 1) ? 4'b1111 : 4'b0000;
            for (int r = 0; r < NR; r++) set_op(r, DW'(r + 20), DW'(r + 30));
            @(negedge clk);
            n_tests++; if (req_ready !== ((n <= 1) ? NR'(1 << n) : 4'b0000)) begin n_fail++; $display("FAIL arst_pre_grant n=%0d: got %b", n, req_ready); end
        end
        @(posedge clk);
        #2;
        req_valid = '1;
        #1;
        n_tests++; if (resp_valid !== 4'b0010 || busy !== 1'b1 || req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL arst_before: got resp_valid %b busy %b ready %b expected 0010 1 0100", resp_valid, busy, req_ready); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || mul_vo !== 1'b0 || clk_en !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL arst_outputs: got ready %b resp_valid %b mul_valid %b clk_en %b busy %b", req_ready, resp_valid, mul_vo, clk_en, busy); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL arst_first_grant: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        for (int n = 0; n < 5; n++) next_cycle();
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_drain_busy: got %b expected 0", busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_stall();
        test_single_requester();
        test_flush();
        test_async_reset();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending results expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
